ds_link_ctrl: RTL

- Link-state controller and transmit scheduler for one IEEE 1355 data-strobe port (A) of the node.
- Sequences the startup handshake: reset, wait, NULL exchange, FCT exchange, run.
- Drives receiver enable/reset. Arbitrates each transmit character slot between FCT, data and NULL.
- Detects disconnect and receive errors, and drops the link back to reset on any fault.

---
 rtl/ds_link_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ds_link_ctrl.sv
// ds_link_ctrl: link-state controller and transmit-slot scheduler for one
// IEEE 1355 data-strobe port. Sequences ERR_RESET -> ERR_WAIT -> READY ->
// STARTED -> CONNECTING -> RUN, drives receiver reset / transmitter enable,
// arbitrates each character slot (FCT > DATA > NULL) and drops the link
// back to ERR_RESET on any fault.
// Build option: define DS_AUTOSTART_EN to let a received NULL start the
// link from READY (with link_en high) in addition to link_start.
module ds_link_ctrl #(
  parameter int T_RESET_CYC = 640,
  parameter int T_WAIT_CYC  = 1280,
  parameter int T_START_CYC = 1280,
  parameter int DISC_CYC    = 85,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_en,
  input  logic       link_start,
  input  logic       rx_toggle,
  input  logic       rx_null_seen,
  input  logic       rx_fct_seen,
  input  logic       rx_char_seen,
  input  logic       rx_err,
  input  logic       tx_ready,
  input  logic       fct_req,
  input  logic       data_req,
  output logic       rx_rst_n,
  output logic       tx_en,
  output logic       tx_load,
  output logic [1:0] tx_kind,
  output logic       fct_gnt,
  output logic       data_gnt,
  output logic       link_run,
  output logic [2:0] state,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    ERR_RESET  = 3'd0,
    ERR_WAIT   = 3'd1,
    READY      = 3'd2,
    STARTED    = 3'd3,
    CONNECTING = 3'd4,
    RUN        = 3'd5
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_NULL = 2'b01;
  localparam logic [1:0] KIND_FCT  = 2'b10;
  localparam logic [1:0] KIND_DATA = 2'b11;

  // Terminal timer values: the state is left on the cycle the timer shows N-1,
  // so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] RESET_END = CNT_W'(T_RESET_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(T_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] START_END = CNT_W'(T_START_CYC - 1);
  localparam logic [CNT_W-1:0] DISC_LAST = CNT_W'(DISC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] disc_cnt;
  logic             disc_armed;
  logic             disconnect;
  logic             count_err;
  logic             start_req;
  logic             state_exit;
  logic             in_tx_state;
  logic             load_ok;
  logic [1:0]       sel_kind;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef DS_AUTOSTART_EN
  assign start_req = link_en && (link_start || rx_null_seen);
`else
  assign start_req = link_en && link_start;
`endif

  // disc_cnt holds the number of silent cycles already elapsed; the current
  // cycle being silent too completes DISC_CYC cycles without activity.
  assign disconnect  = disc_armed && !rx_toggle && (disc_cnt >= DISC_LAST);

  assign in_tx_state = (cur_state == STARTED) || (cur_state == CONNECTING) ||
                       (cur_state == RUN);
  assign state_exit  = (next_state != cur_state);
  assign load_ok     = in_tx_state && tx_ready && !tx_load && !state_exit;

  assign state    = cur_state;
  assign rx_rst_n = (cur_state != ERR_RESET);
  assign tx_en    = in_tx_state;
  assign link_run = (cur_state == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ERR_RESET;
    else        cur_state <= next_state;
  end

  // Next-state decode; counted faults are checked before forward moves so an
  // error always wins, and link_en=0 drops the link without being counted.
  always_comb begin
    next_state = cur_state;
    count_err  = 1'b0;
    case (cur_state)
      ERR_RESET: begin
        if (timer == RESET_END) next_state = ERR_WAIT;
      end
      ERR_WAIT, READY: begin
        if (rx_err || rx_fct_seen || rx_char_seen || disconnect) begin
          next_state = ERR_RESET;
          count_err  = 1'b1;
        end else if (cur_state == ERR_WAIT) begin
          if (timer == WAIT_END) next_state = READY;
        end else if (start_req) begin
          next_state = STARTED;
        end
      end
      STARTED: begin
        if (rx_err || disconnect || (timer == START_END)) begin
          next_state = ERR_RESET;
          count_err  = 1'b1;
        end else if (!link_en) begin
          next_state = ERR_RESET;
        end else if (rx_null_seen) begin
          next_state = CONNECTING;
        end
      end
      CONNECTING: begin
        if (rx_err || disconnect || rx_char_seen || (timer == START_END)) begin
          next_state = ERR_RESET;
          count_err  = 1'b1;
        end else if (!link_en) begin
          next_state = ERR_RESET;
        end else if (rx_fct_seen) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (rx_err || disconnect) begin
          next_state = ERR_RESET;
          count_err  = 1'b1;
        end else if (!link_en) begin
          next_state = ERR_RESET;
        end
      end
      default: next_state = ERR_RESET;
    endcase
  end

  // Shared state timer: restarts on every state change, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             timer <= '0;
    else if (state_exit)    timer <= '0;
    else if (timer != CNT_MAX) timer <= timer + 1'b1;
  end

  // Disconnect watchdog: armed by the first receive edge outside ERR_RESET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_armed <= 1'b0;
      disc_cnt   <= '0;
    end else if (cur_state == ERR_RESET) begin
      disc_armed <= 1'b0;
      disc_cnt   <= '0;
    end else if (rx_toggle) begin
      disc_armed <= 1'b1;
      disc_cnt   <= '0;
    end else if (disc_armed && (disc_cnt != DISC_LAST)) begin
      disc_cnt <= disc_cnt + 1'b1;
    end
  end

  // Saturating count of fault exits into ERR_RESET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_count <= 8'd0;
    else if (count_err) err_count <= sat_inc8(err_count);
  end

  // Slot arbitration: FCT only once connecting, DATA only in RUN, else NULL.
  always_comb begin
    sel_kind = KIND_NULL;
    if (fct_req && ((cur_state == CONNECTING) || (cur_state == RUN)))
      sel_kind = KIND_FCT;
    else if (data_req && (cur_state == RUN))
      sel_kind = KIND_DATA;
  end

  // Registered load strobe and grants; tx_kind is held between loads and
  // cleared whenever a transmitting state is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_load  <= 1'b0;
      tx_kind  <= KIND_NONE;
      fct_gnt  <= 1'b0;
      data_gnt <= 1'b0;
    end else begin
      tx_load  <= load_ok;
      fct_gnt  <= 1'b0;
      data_gnt <= 1'b0;
      if (state_exit && in_tx_state) begin
        tx_kind <= KIND_NONE;
      end else if (load_ok) begin
        tx_kind  <= sel_kind;
        fct_gnt  <= (sel_kind == KIND_FCT);
        data_gnt <= (sel_kind == KIND_DATA);
      end
    end
  end

endmodule
